// File: rtl/ppu_obj_fifo_n.sv
// rtl/ppu_obj_fifo_n.sv - parametrised PPU sprite output FIFO with flip, clipping and slot rejection
// Optional macro OBJ_FIFO_SPR0_EN: per-slot sprite-0 tag driving SPR0HIT (constant 0 when undefined).
module ppu_obj_fifo_n #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
) (
  input  logic              CLK,
  input  logic              n_RES,
  input  logic              PCLK_EN,
  input  logic              Z_HPOS,
  input  logic              VIS,
  input  logic              CLPO,
  input  logic              LD,
  input  logic [SLOT_W-1:0] LD_SLOT,
  input  logic [7:0]        LD_X,
  input  logic [7:0]        LD_ATTR,
  input  logic [7:0]        LD_PAT_A,
  input  logic [7:0]        LD_PAT_B,
  input  logic              LD_SPR0,
  output logic [3:0]        ZCOL,
  output logic              OPAQUE,
  output logic              ZPRIO,
  output logic              SPR0HIT
);

  localparam logic [8:0] POS_MAX = 9'd511;

  logic [7:0]           x_q     [NUM_SLOTS];
  logic [7:0]           pat_a_q [NUM_SLOTS];
  logic [7:0]           pat_b_q [NUM_SLOTS];
  logic [1:0]           pal_q   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] prio_q;
  logic [NUM_SLOTS-1:0] armed_q;
  logic [NUM_SLOTS-1:0] spr0_vec;
  logic [8:0]           pos_q;

  logic [7:0] ld_a;
  logic [7:0] ld_b;
  logic       clip;
  logic       win_found;
  logic [3:0] win_col;
  logic       win_prio;
  logic       win_spr0;

  logic unused_attr;
  assign unused_attr = &{1'b0, LD_ATTR[7], LD_ATTR[4:2]};

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Flip is applied once at load so the shifter always emits MSB first.
  assign ld_a = LD_ATTR[6] ? rev8(LD_PAT_A) : LD_PAT_A;
  assign ld_b = LD_ATTR[6] ? rev8(LD_PAT_B) : LD_PAT_B;
  assign clip = CLPO && (pos_q < 9'd8);

`ifdef OBJ_FIFO_SPR0_EN
  logic [NUM_SLOTS-1:0] spr0_q;
  assign spr0_vec = spr0_q;
`else
  logic unused_spr0;
  assign unused_spr0 = LD_SPR0;
  assign spr0_vec    = '0;
`endif

  // Scan from the top so the lowest-index opaque candidate overrides the rest.
  always_comb begin
    win_found = 1'b0;
    win_col   = 4'd0;
    win_prio  = 1'b0;
    win_spr0  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (armed_q[i] && (x_q[i] == 8'd0) && (pat_a_q[i][7] || pat_b_q[i][7])) begin
        win_found = 1'b1;
        win_col   = {pal_q[i], pat_b_q[i][7], pat_a_q[i][7]};
        win_prio  = prio_q[i];
        win_spr0  = spr0_vec[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]     <= 8'd0;
        pat_a_q[i] <= 8'd0;
        pat_b_q[i] <= 8'd0;
        pal_q[i]   <= 2'd0;
      end
      prio_q  <= '0;
      armed_q <= '0;
`ifdef OBJ_FIFO_SPR0_EN
      spr0_q  <= '0;
`endif
      pos_q   <= 9'd0;
      ZCOL    <= 4'd0;
      OPAQUE  <= 1'b0;
      ZPRIO   <= 1'b0;
      SPR0HIT <= 1'b0;
    end else begin
      if (PCLK_EN) begin
        if (VIS && !Z_HPOS) begin
          if (win_found && !clip) begin
            ZCOL    <= win_col;
            OPAQUE  <= 1'b1;
            ZPRIO   <= win_prio;
            SPR0HIT <= win_spr0;
          end else begin
            ZCOL    <= 4'd0;
            OPAQUE  <= 1'b0;
            ZPRIO   <= 1'b0;
            SPR0HIT <= 1'b0;
          end
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (armed_q[i]) begin
              if (x_q[i] == 8'd0) begin
                pat_a_q[i] <= {pat_a_q[i][6:0], 1'b0};
                pat_b_q[i] <= {pat_b_q[i][6:0], 1'b0};
              end else begin
                x_q[i] <= x_q[i] - 8'd1;
              end
            end
          end
          if (pos_q != POS_MAX) pos_q <= pos_q + 9'd1;
        end else begin
          ZCOL    <= 4'd0;
          OPAQUE  <= 1'b0;
          ZPRIO   <= 1'b0;
          SPR0HIT <= 1'b0;
        end
      end
      if (Z_HPOS) begin
        armed_q <= '1;
        pos_q   <= 9'd0;
      end
      // Out-of-range LD_SLOT matches no slot, so the load is dropped.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (LD && (LD_SLOT == SLOT_W'(i))) begin
          x_q[i]     <= LD_X;
          pat_a_q[i] <= ld_a;
          pat_b_q[i] <= ld_b;
          pal_q[i]   <= LD_ATTR[1:0];
          prio_q[i]  <= LD_ATTR[5];
          armed_q[i] <= Z_HPOS;
`ifdef OBJ_FIFO_SPR0_EN
          spr0_q[i]  <= LD_SPR0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_obj_fifo_n.sv
// tb/tb_ppu_obj_fifo_n.sv - directed self-checking bench for ppu_obj_fifo_n (NUM_SLOTS=5)
module tb_ppu_obj_fifo_n;

`ifdef OBJ_FIFO_SPR0_EN
  localparam logic SPR0_ON = 1'b1;
`else
  localparam logic SPR0_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       n_RES = 1'b0;
  logic       PCLK_EN = 1'b1;
  logic       Z_HPOS = 1'b0;
  logic       VIS = 1'b0;
  logic       CLPO = 1'b0;
  logic       LD = 1'b0;
  logic [2:0] LD_SLOT = 3'd0;
  logic [7:0] LD_X = 8'd0;
  logic [7:0] LD_ATTR = 8'd0;
  logic [7:0] LD_PAT_A = 8'd0;
  logic [7:0] LD_PAT_B = 8'd0;
  logic       LD_SPR0 = 1'b0;
  logic [3:0] ZCOL;
  logic       OPAQUE;
  logic       ZPRIO;
  logic       SPR0HIT;

  int n_checks = 0;
  int n_errors = 0;

  ppu_obj_fifo_n #(.NUM_SLOTS(5), .SLOT_W(3)) dut (
    .CLK(CLK), .n_RES(n_RES), .PCLK_EN(PCLK_EN), .Z_HPOS(Z_HPOS), .VIS(VIS),
    .CLPO(CLPO), .LD(LD), .LD_SLOT(LD_SLOT), .LD_X(LD_X), .LD_ATTR(LD_ATTR),
    .LD_PAT_A(LD_PAT_A), .LD_PAT_B(LD_PAT_B), .LD_SPR0(LD_SPR0),
    .ZCOL(ZCOL), .OPAQUE(OPAQUE), .ZPRIO(ZPRIO), .SPR0HIT(SPR0HIT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    n_RES = 1'b0;
    tick();
    tick();
    n_RES = 1'b1;
  endtask

  task automatic load(input logic [2:0] slot, input logic [7:0] x, input logic [7:0] attr,
                      input logic [7:0] a, input logic [7:0] b, input logic s0);
    LD = 1'b1; LD_SLOT = slot; LD_X = x; LD_ATTR = attr;
    LD_PAT_A = a; LD_PAT_B = b; LD_SPR0 = s0;
    tick();
    LD = 1'b0;
  endtask

  task automatic zhpos();
    Z_HPOS = 1'b1;
    tick();
    Z_HPOS = 1'b0;
  endtask

  task automatic pixel();
    VIS = 1'b1;
    tick();
    VIS = 1'b0;
  endtask

  task automatic clip_line(input logic clpo);
    logic [3:0] ec;
    do_reset();
    load(3'd0, 8'd4, 8'h00, 8'hFF, 8'h00, 1'b0);
    CLPO = clpo;
    zhpos();
    for (int p = 0; p < 13; p++) begin
      pixel();
      ec = (p >= 4 && p <= 11 && !(clpo && p < 8)) ? 4'h1 : 4'h0;
      check($sformatf("clip%0d_col_p%0d", clpo, p), 8'(ZCOL), 8'(ec));
      check($sformatf("clip%0d_opq_p%0d", clpo, p), 8'(OPAQUE), 8'(ec != 4'h0));
    end
    CLPO = 1'b0;
  endtask

  initial begin
    logic [3:0] ec;
    logic       ep;

    // reset state and asynchronous mid-line reset
    do_reset();
    check("rst_col", 8'(ZCOL), 8'h0);
    check("rst_opq", 8'(OPAQUE), 8'h0);
    check("rst_prio", 8'(ZPRIO), 8'h0);
    check("rst_hit", 8'(SPR0HIT), 8'h0);
    load(3'd0, 8'd0, 8'h00, 8'hFF, 8'h00, 1'b0);
    zhpos();
    pixel();
    check("pre_async_opq", 8'(OPAQUE), 8'h1);
    check("pre_async_col", 8'(ZCOL), 8'h1);
    #2 n_RES = 1'b0;
    #1;
    check("async_col", 8'(ZCOL), 8'h0);
    check("async_opq", 8'(OPAQUE), 8'h0);
    #1 n_RES = 1'b1;
    zhpos();
    for (int p = 0; p < 8; p++) begin
      pixel();
      check($sformatf("post_rst_opq_p%0d", p), 8'(OPAQUE), 8'h0);
    end

    // single sprite, slot 2, X=3
    do_reset();
    load(3'd2, 8'd3, 8'h03, 8'hF0, 8'h0F, 1'b0);
    zhpos();
    for (int p = 0; p < 12; p++) begin
      pixel();
      ec = (p >= 3 && p <= 6) ? 4'hD : (p >= 7 && p <= 10) ? 4'hE : 4'h0;
      check($sformatf("single_col_p%0d", p), 8'(ZCOL), 8'(ec));
      check($sformatf("single_opq_p%0d", p), 8'(OPAQUE), 8'(ec != 4'h0));
    end

    // priority between slots and horizontal flip
    do_reset();
    load(3'd0, 8'd5, 8'h40, 8'h01, 8'h00, 1'b0);
    load(3'd1, 8'd5, 8'h21, 8'hFF, 8'h00, 1'b0);
    zhpos();
    for (int p = 0; p < 14; p++) begin
      pixel();
      ec = (p == 5) ? 4'h1 : (p >= 6 && p <= 12) ? 4'h5 : 4'h0;
      ep = (p >= 6 && p <= 12);
      check($sformatf("prio_col_p%0d", p), 8'(ZCOL), 8'(ec));
      check($sformatf("prio_opq_p%0d", p), 8'(OPAQUE), 8'(ec != 4'h0));
      check($sformatf("prio_zprio_p%0d", p), 8'(ZPRIO), 8'(ep));
    end

    // left-edge clipping on and off
    clip_line(1'b1);
    clip_line(1'b0);

    // PCLK_EN=0 holds, VIS=0 blanks without shifting
    do_reset();
    load(3'd0, 8'd0, 8'h00, 8'hF0, 8'h00, 1'b0);
    zhpos();
    pixel();
    check("hold_first_col", 8'(ZCOL), 8'h1);
    PCLK_EN = 1'b0;
    pixel();
    pixel();
    PCLK_EN = 1'b1;
    check("hold_col", 8'(ZCOL), 8'h1);
    check("hold_opq", 8'(OPAQUE), 8'h1);
    tick();
    check("blank_opq", 8'(OPAQUE), 8'h0);
    for (int p = 1; p < 5; p++) begin
      pixel();
      check($sformatf("resume_col_p%0d", p), 8'(ZCOL), (p < 4) ? 8'h1 : 8'h0);
    end

    // out-of-range slot index is ignored
    do_reset();
    load(3'd1, 8'd0, 8'h02, 8'hFF, 8'h00, 1'b0);
    load(3'd6, 8'd0, 8'h03, 8'h00, 8'hFF, 1'b1);
    load(3'd5, 8'd0, 8'h03, 8'h00, 8'hFF, 1'b1);
    zhpos();
    pixel();
    check("inv_col", 8'(ZCOL), 8'h9);
    check("inv_hit", 8'(SPR0HIT), 8'h0);

    // load coinciding with line start arms the slot
    do_reset();
    Z_HPOS = 1'b1;
    load(3'd3, 8'd2, 8'h01, 8'hFF, 8'h00, 1'b0);
    Z_HPOS = 1'b0;
    for (int p = 0; p < 11; p++) begin
      pixel();
      ec = (p >= 2 && p <= 9) ? 4'h5 : 4'h0;
      check($sformatf("simul_col_p%0d", p), 8'(ZCOL), 8'(ec));
    end

    // sprite-0 hit
    do_reset();
    load(3'd4, 8'd0, 8'h00, 8'h80, 8'h00, 1'b1);
    zhpos();
    pixel();
    check("s0_col", 8'(ZCOL), 8'h1);
    check("s0_hit_p0", 8'(SPR0HIT), 8'(SPR0_ON));
    pixel();
    check("s0_hit_p1", 8'(SPR0HIT), 8'h0);
    check("s0_opq_p1", 8'(OPAQUE), 8'h0);
    do_reset();
    load(3'd4, 8'd0, 8'h00, 8'h80, 8'h00, 1'b1);
    load(3'd0, 8'd0, 8'h02, 8'h80, 8'h00, 1'b0);
    zhpos();
    pixel();
    check("s0_masked_col", 8'(ZCOL), 8'h9);
    check("s0_masked_hit", 8'(SPR0HIT), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
